// File: rtl/regfile_mp_if.sv
// Bundle of the register file's write, read and reserve ports.
// The core drives the master side and the register file sits on the slave side.
interface regfile_mp_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 1
);
  logic [NWRITE-1:0]        wen;
  logic [NWRITE*REG_W-1:0]  wsel;
  logic [NWRITE*DATA_W-1:0] wdat;
  logic [NREAD*REG_W-1:0]   rsel;
  logic [NREAD*DATA_W-1:0]  rdat;
  logic [NREAD-1:0]         rbusy;
  logic                     rsv_en;
  logic [REG_W-1:0]         rsv_sel;
  logic                     any_busy;

  modport master (
    output wen, wsel, wdat, rsel, rsv_en, rsv_sel,
    input  rdat, rbusy, any_busy
  );

  modport slave (
    input  wen, wsel, wdat, rsel, rsv_en, rsv_sel,
    output rdat, rbusy, any_busy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with a pending-write scoreboard; r0 reads as zero.
// Define REGFILE_MP_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 1
) (
  input logic         clk,
  input logic         rst,
  regfile_mp_if.slave bus
);
  localparam int unsigned NREG = 2 ** REG_W;

  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] rf_d [NREG];
  logic [NREG-1:0]   pend_q, pend_d;

  logic [NREAD*DATA_W-1:0] rdat_c;
  logic [NREAD-1:0]        rbusy_c;

  // Ascending port order lets the highest write port win; reserve is applied last so a
  // new producer keeps the register pending even when the old one retires this cycle.
  always_comb begin
    logic [REG_W-1:0] ws;
    rf_d   = rf_q;
    pend_d = pend_q;
    for (int unsigned i = 0; i < NWRITE; i++) begin
      ws = bus.wsel[i*REG_W +: REG_W];
      if (bus.wen[i] && (ws != '0)) begin
        rf_d[ws]   = bus.wdat[i*DATA_W +: DATA_W];
        pend_d[ws] = 1'b0;
      end
    end
    if (bus.rsv_en && (bus.rsv_sel != '0)) begin
      pend_d[bus.rsv_sel] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q   <= '{default: '0};
      pend_q <= '0;
    end else begin
      rf_q   <= rf_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    logic [REG_W-1:0] rs;
`ifdef REGFILE_MP_BYPASS_EN
    logic [REG_W-1:0] ws;
`endif
    rdat_c  = '0;
    rbusy_c = '0;
    for (int unsigned j = 0; j < NREAD; j++) begin
      rs = bus.rsel[j*REG_W +: REG_W];
      if (rs != '0) begin
        rdat_c[j*DATA_W +: DATA_W] = rf_q[rs];
        rbusy_c[j]                 = pend_q[rs];
`ifdef REGFILE_MP_BYPASS_EN
        for (int unsigned i = 0; i < NWRITE; i++) begin
          ws = bus.wsel[i*REG_W +: REG_W];
          if (bus.wen[i] && (ws == rs)) begin
            rdat_c[j*DATA_W +: DATA_W] = bus.wdat[i*DATA_W +: DATA_W];
            rbusy_c[j]                 = 1'b0;
          end
        end
`endif
      end
    end
  end

  assign bus.rdat     = rdat_c;
  assign bus.rbusy    = rbusy_c;
  assign bus.any_busy = |pend_q;
endmodule
